uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Oversampling UART receiver: recovers 8N1 frames from serial rxd and pushes each
//  good byte into the 64-deep RX FIFO (fifo_rx) in the uart top via a 1-cycle write strobe.
//  Sits between the baud generator (consumes its tick) and fifo_rx (drives wr_en/data_in).
//  Flags framing, overrun and (optionally) parity errors as 1-cycle pulses.
// PARAMETERS
//  D_W         8   data bits per frame, LSB first
//  B_TICK      16  baud ticks per bit period (oversampling factor); even, >=4
//  PARITY_ODD  0   parity sense when UART_RX_PARITY_EN defined: 0 even, 1 odd
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous, active-high reset
//  baud_tick    in   1    1-cycle strobe, B_TICK per bit period, from baud generator
//  rxd          in   1    asynchronous serial input, idle high
//  fifo_full    in   1    fifo_rx full flag
//  rx_data      out  D_W  received byte, to fifo_rx data_in; valid while rx_wr_en=1
//  rx_wr_en     out  1    1-cycle write strobe to fifo_rx wr_en
//  rx_busy      out  1    high from start-bit detect until return to IDLE
//  frame_err    out  1    1-cycle pulse: stop bit sampled low
//  overrun_err  out  1    1-cycle pulse: good frame dropped, fifo_full=1
//  parity_err   out  1    1-cycle pulse: parity mismatch (tied 0 without macro)
// BEHAVIOUR
//  - rxd passes a 2-FF synchronizer (reset value 1); FSM uses synced rxd_s only.
//  - Reset: state=IDLE, counters=0, shift reg=0; rx_data=0, all strobes/flags/busy=0.
//  - tick_cnt ($clog2(B_TICK) bits) advances only on baud_tick; bit_cnt counts data bits.
//  - IDLE: rxd_s==0 -> START, tick_cnt<=0. No baud_tick needed to leave IDLE.
//  - START: on baud_tick with tick_cnt==B_TICK/2-1: rxd_s==0 -> DATA, tick_cnt<=0
//    (now at bit centre); rxd_s==1 -> IDLE (glitch rejected, no flag).
//  - DATA: on baud_tick with tick_cnt==B_TICK-1: shift rxd_s into MSB (shift right),
//    tick_cnt<=0, bit_cnt++; after D_W-th bit -> STOP (or PARITY if macro).
//  - PARITY (macro only): sample on same rule; compare against XOR of data ^ PARITY_ODD.
//  - STOP: on baud_tick with tick_cnt==B_TICK-1 sample rxd_s, then -> IDLE:
//    rxd_s==0 -> frame_err pulse, no write; rxd_s==1 & parity bad -> parity_err, no write;
//    else fifo_full=1 -> overrun_err pulse, no write; else rx_wr_en pulse, rx_data=byte.
//  - Strobes assert the cycle after the stop-bit sample tick, for exactly 1 clk.
//  - rx_data holds last written byte until next write (not cleared on errors).
//  - Exactly one of rx_wr_en/frame_err/overrun_err/parity_err per completed frame.
//  - Line held low after frame_err: IDLE re-enters START immediately; break condition
//    yields repeated frame_err, one per frame time (0x00 data, never written).
//  - Reset mid-frame: abort, no strobe; next frame begins on a fresh falling edge.
//  - baud_tick absent: FSM holds state; no timeout.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame = start, D_W data, 1 parity, 1 stop; PARITY state
//    present; parity_err driven.
//  Not defined: 8N1-style frame (no parity bit); PARITY state absent; parity_err=0.
// STRUCTURE
//  - Shared header uart_defs.vh: FSM state localparams (IDLE/START/DATA/PARITY/STOP),
//    default D_W/B_TICK, shared with uart_tx.
//  - One sub-module: uart_sync2 (2-FF synchronizer, parameter RST_VAL), reusable for
//    other async inputs. Everything else is flat in uart_rx.
// TESTING (baud_tick=1 every clk, B_TICK=16 unless noted)
//  - Send 0x55 then 0xA3, fifo_full=0 -> two rx_wr_en pulses, rx_data 0x55 then 0xA3.
//  - 3-clk low glitch on idle rxd -> back to IDLE, rx_busy drops, no strobe/flag.
//  - Frame 0x3C with stop bit driven 0 -> frame_err one pulse, rx_wr_en never high.
//  - fifo_full=1 during frame 0x7E -> overrun_err pulse, no rx_wr_en, rx_data unchanged.
//  - rst asserted mid-DATA of 0xFF -> no strobe; following 0x12 received correctly.
//  - Macro on, PARITY_ODD=0: 0x07 with parity 1 -> write; parity 0 -> parity_err only.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
//  Shared definitions for the UART receive path: FSM state encoding and the
//  default frame geometry. The TX side can import the same package so both
//  directions agree on state names and defaults.
//
//  Contents:
//   DefDataWidth  default data bits per frame
//   DefBaudTick   default baud ticks per bit period (oversampling factor)
//   rx_state_e    receiver FSM states
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefBaudTick  = 16;

    // StParity exists in the encoding for both builds so the state values stay
    // stable; the receiver only ever enters it when parity is compiled in.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// ----------------------------------------------------------------------------
// uart_rx_sync2
//  Two-flop synchronizer for a single asynchronous input. Reusable for any
//  slow asynchronous control line; the reset value lets an idle-high line
//  such as a UART rxd come out of reset without a false edge.
//
//  Parameters:
//   RST_VAL  value both flops take on reset
//  Ports:
//   clk  in   destination clock
//   rst  in   synchronous, active-high reset
//   d    in   asynchronous input
//   q    out  synchronized output (2 clk latency)
// ----------------------------------------------------------------------------
module uart_rx_sync2 #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//  Oversampling UART receiver. Recovers start / D_W data (LSB first) /
//  [parity] / stop frames from rxd and pushes each good byte into the RX FIFO
//  with a 1-cycle write strobe. Framing, overrun and parity errors are
//  reported as 1-cycle pulses; exactly one strobe or flag fires per frame.
//
//  Build option:
//   UART_RX_PARITY_EN  when defined, a parity bit follows the data bits and
//                      parity_err is driven; otherwise parity_err is tied 0.
//
//  Parameters:
//   D_W         data bits per frame
//   B_TICK      baud ticks per bit period (even, >= 4)
//   PARITY_ODD  parity sense with parity enabled: 0 even, 1 odd
//  Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   baud_tick    in   1-cycle strobe, B_TICK per bit period
//   rxd          in   asynchronous serial input, idle high
//   fifo_full    in   RX FIFO full flag
//   rx_data      out  last written byte, valid while rx_wr_en=1
//   rx_wr_en     out  1-cycle FIFO write strobe
//   rx_busy      out  high from start-bit detect until back in idle
//   frame_err    out  1-cycle pulse: stop bit sampled low
//   overrun_err  out  1-cycle pulse: good frame dropped, FIFO full
//   parity_err   out  1-cycle pulse: parity mismatch
// ----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned D_W        = DefDataWidth,
    parameter int unsigned B_TICK     = DefBaudTick,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_tick,
    input  logic           rxd,
    input  logic           fifo_full,
    output logic [D_W-1:0] rx_data,
    output logic           rx_wr_en,
    output logic           rx_busy,
    output logic           frame_err,
    output logic           overrun_err,
    output logic           parity_err
);

    localparam int unsigned TW = $clog2(B_TICK);
    localparam int unsigned BW = $clog2(D_W + 1);

    localparam logic [TW-1:0] HalfLast = TW'(B_TICK / 2 - 1);
    localparam logic [TW-1:0] FullLast = TW'(B_TICK - 1);
    localparam logic [BW-1:0] BitLast  = BW'(D_W - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AfterData = StParity;
`else
    localparam rx_state_e AfterData = StStop;
`endif

    // ------------------------------------------------------------------
    // Input synchronizer: idle-high reset value avoids a false start bit
    // ------------------------------------------------------------------
    logic rxd_s;

    uart_rx_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    rx_state_e      state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [D_W-1:0] shift_q, shift_d;
    logic [D_W-1:0] rx_data_q, rx_data_d;
    logic           wr_q, wr_d;
    logic           frame_q, frame_d;
    logic           overrun_q, overrun_d;
    logic           perr_q, perr_d;
    logic           par_bad;

    // Sample points: half a bit into the start bit, then one full bit apart
    logic mid_hit;
    logic bit_hit;

    assign mid_hit = baud_tick && (tick_cnt_q == HalfLast);
    assign bit_hit = baud_tick && (tick_cnt_q == FullLast);

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;

    // Received parity must equal XOR of the data bits, inverted for odd sense
    assign par_bad = par_bit_q != ((^shift_q) ^ PARITY_ODD);
`else
    logic unused_parity_odd;

    assign unused_parity_odd = PARITY_ODD;
    assign par_bad           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // Leaving idle needs no tick, so the start bit is caught promptly
            StIdle: begin
                if (!rxd_s) state_d = StStart;
            end
            // High at the start-bit centre means it was a glitch
            StStart: begin
                if (mid_hit) state_d = rxd_s ? StIdle : StData;
            end
            StData: begin
                if (bit_hit && (bit_cnt_q == BitLast)) state_d = AfterData;
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_hit) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_hit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs, counters and frame result
    // ------------------------------------------------------------------
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        wr_d       = 1'b0;
        frame_d    = 1'b0;
        overrun_d  = 1'b0;
        perr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif

        unique case (state_q)
            StIdle: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
            StStart: begin
                if (baud_tick) tick_cnt_d = mid_hit ? '0 : tick_cnt_q + 1'b1;
            end
            StData: begin
                if (bit_hit) begin
                    tick_cnt_d = '0;
                    shift_d    = {rxd_s, shift_q[D_W-1:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end else if (baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_hit) begin
                    tick_cnt_d = '0;
                    par_bit_d  = rxd_s;
                end else if (baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_hit) begin
                    tick_cnt_d = '0;
                    // Priority: framing, then parity, then overrun
                    if (!rxd_s) begin
                        frame_d = 1'b1;
                    end else if (par_bad) begin
                        perr_d = 1'b1;
                    end else if (fifo_full) begin
                        overrun_d = 1'b1;
                    end else begin
                        wr_d      = 1'b1;
                        rx_data_d = shift_q;
                    end
                end else if (baud_tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            wr_q       <= 1'b0;
            frame_q    <= 1'b0;
            overrun_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            wr_q       <= wr_d;
            frame_q    <= frame_d;
            overrun_q  <= overrun_d;
            perr_q     <= perr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_q <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
        end
    end
`endif

    assign rx_data     = rx_data_q;
    assign rx_wr_en    = wr_q;
    assign rx_busy     = (state_q != StIdle);
    assign frame_err   = frame_q;
    assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//  Directed plus randomized frames driven on rxd. Expected results come from
//  the frame rules: a low stop bit is a framing error, then a bad parity bit,
//  then a full FIFO is an overrun, otherwise the byte is written. Strobes and
//  flags are counted once per low clock phase, so any pulse wider than one
//  clock shows up as an extra event.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int unsigned D_W        = 8;
    localparam int unsigned B_TICK     = 16;
    localparam bit          PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit          PAR_EN     = 1'b1;
`else
    localparam bit          PAR_EN     = 1'b0;
`endif
    // Bits sampled after the start bit, and frame period under a held-low line
    localparam int unsigned NBITS      = D_W + 1 + (PAR_EN ? 1 : 0);
    localparam int unsigned BREAK_PER  = 1 + B_TICK / 2 + NBITS * B_TICK;

    logic           clk = 1'b0;
    logic           rst;
    logic           baud_tick = 1'b1;
    logic           rxd;
    logic           fifo_full;
    logic [D_W-1:0] rx_data;
    logic           rx_wr_en;
    logic           rx_busy;
    logic           frame_err;
    logic           overrun_err;
    logic           parity_err;

    uart_rx #(
        .D_W        (D_W),
        .B_TICK     (B_TICK),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rxd         (rxd),
        .fifo_full   (fifo_full),
        .rx_data     (rx_data),
        .rx_wr_en    (rx_wr_en),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Baud tick every tick_div clocks
    int unsigned tick_div = 1;
    int unsigned tick_ctr = 0;
    always @(negedge clk) begin
        if (tick_div <= 1) begin
            baud_tick <= 1'b1;
            tick_ctr  <= 0;
        end else begin
            baud_tick <= (tick_ctr == 0);
            tick_ctr  <= (tick_ctr + 1) % tick_div;
        end
    end

    // Event monitor
    int unsigned    n_wr = 0;
    int unsigned    n_fe = 0;
    int unsigned    n_ov = 0;
    int unsigned    n_pe = 0;
    logic [D_W-1:0] last_wr = '0;
    always @(negedge clk) begin
        if (rx_wr_en) begin
            n_wr    <= n_wr + 1;
            last_wr <= rx_data;
        end
        if (frame_err)   n_fe <= n_fe + 1;
        if (overrun_err) n_ov <= n_ov + 1;
        if (parity_err)  n_pe <= n_pe + 1;
    end

    int             checks = 0;
    int             passed = 0;
    int             failed = 0;
    logic [D_W-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [D_W-1:0] data, input bit par_val,
                              input bit stop_val);
        int unsigned bclk;
        bclk = B_TICK * ((tick_div <= 1) ? 1 : tick_div);
        rxd = 1'b0;
        wait_clk(bclk);
        for (int i = 0; i < int'(D_W); i++) begin
            rxd = data[i];
            wait_clk(bclk);
        end
        if (PAR_EN) begin
            rxd = par_val;
            wait_clk(bclk);
        end
        rxd = stop_val;
        wait_clk(bclk);
        rxd = 1'b1;
    endtask

    // One frame checked against the frame rules
    task automatic run_frame(input string tag, input logic [D_W-1:0] data,
                             input bit stop_val, input bit par_flip, input bit full);
        int unsigned b_wr, b_fe, b_ov, b_pe;
        int unsigned e_wr, e_fe, e_ov, e_pe;
        bit          par_val;
        b_wr = n_wr; b_fe = n_fe; b_ov = n_ov; b_pe = n_pe;
        e_wr = 0; e_fe = 0; e_ov = 0; e_pe = 0;
        par_val = (^data) ^ PARITY_ODD ^ par_flip;
        if (!stop_val)                e_fe = 1;
        else if (PAR_EN && par_flip)  e_pe = 1;
        else if (full)                e_ov = 1;
        else begin
            e_wr     = 1;
            exp_data = data;
        end
        fifo_full = full;
        send_frame(data, par_val, stop_val);
        wait_clk(12 * ((tick_div <= 1) ? 1 : tick_div));
        fifo_full = 1'b0;
        chk($sformatf("%s wr_cnt", tag), n_wr - b_wr, e_wr);
        chk($sformatf("%s frame_cnt", tag), n_fe - b_fe, e_fe);
        chk($sformatf("%s overrun_cnt", tag), n_ov - b_ov, e_ov);
        chk($sformatf("%s parity_cnt", tag), n_pe - b_pe, e_pe);
        chk($sformatf("%s rx_data", tag), {24'b0, rx_data}, {24'b0, exp_data});
        if (e_wr == 1) chk($sformatf("%s wr_data", tag), {24'b0, last_wr}, {24'b0, data});
        chk($sformatf("%s busy_after", tag), {31'b0, rx_busy}, 32'd0);
    endtask

    initial begin
        int unsigned b_wr, b_fe;

        rst       = 1'b1;
        rxd       = 1'b1;
        fifo_full = 1'b0;
        wait_clk(4);
        chk("rst rx_data", {24'b0, rx_data}, 32'd0);
        chk("rst wr_en", {31'b0, rx_wr_en}, 32'd0);
        chk("rst busy", {31'b0, rx_busy}, 32'd0);
        chk("rst flags", {29'b0, frame_err, overrun_err, parity_err}, 32'd0);
        rst = 1'b0;
        wait_clk(8);
        chk("idle busy", {31'b0, rx_busy}, 32'd0);

        // Basic reception
        run_frame("f55", 8'h55, 1'b1, 1'b0, 1'b0);
        run_frame("fA3", 8'hA3, 1'b1, 1'b0, 1'b0);

        // 3-clk glitch: start detected, rejected at the start-bit centre
        b_wr = n_wr; b_fe = n_fe;
        rxd = 1'b0;
        wait_clk(3);
        rxd = 1'b1;
        wait_clk(2);
        chk("glitch busy_hi", {31'b0, rx_busy}, 32'd1);
        wait_clk(20);
        chk("glitch busy_lo", {31'b0, rx_busy}, 32'd0);
        chk("glitch events", (n_wr - b_wr) + (n_fe - b_fe) + n_ov + n_pe, 32'd0);

        // Framing error and overrun keep rx_data
        run_frame("f3C_stop0", 8'h3C, 1'b0, 1'b0, 1'b0);
        run_frame("f7E_full", 8'h7E, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of the data bits of 0xFF
        b_wr = n_wr; b_fe = n_fe;
        rxd = 1'b0;
        wait_clk(B_TICK);
        rxd = 1'b1;
        wait_clk(3 * B_TICK);
        chk("midrst busy_hi", {31'b0, rx_busy}, 32'd1);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        chk("midrst busy_lo", {31'b0, rx_busy}, 32'd0);
        wait_clk(10 * B_TICK);
        chk("midrst events", (n_wr - b_wr) + (n_fe - b_fe), 32'd0);
        chk("midrst rx_data", {24'b0, rx_data}, 32'd0);
        exp_data = '0;
        run_frame("f12", 8'h12, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        run_frame("f07_par_ok", 8'h07, 1'b1, 1'b0, 1'b0);
        run_frame("f07_par_bad", 8'h07, 1'b1, 1'b1, 1'b0);
`endif

        // Break: line held low gives one framing error per frame time
        b_wr = n_wr; b_fe = n_fe;
        rxd = 1'b0;
        wait_clk(3 * BREAK_PER + 4);
        rxd = 1'b1;
        wait_clk(3 * B_TICK);
        chk("break frame_cnt", n_fe - b_fe, 32'd3);
        chk("break wr_cnt", n_wr - b_wr, 32'd0);
        chk("break busy", {31'b0, rx_busy}, 32'd0);

        // Sparse baud ticks: the FSM holds between ticks
        tick_div = 3;
        wait_clk(6);
        run_frame("fC5_div3", 8'hC5, 1'b1, 1'b0, 1'b0);
        tick_div = 1;
        wait_clk(6);

        // Randomized frames
        for (int i = 0; i < 10; i++) begin
            logic [D_W-1:0] d;
            bit             stop_v, flip, full;
            d      = D_W'($urandom);
            stop_v = ($urandom % 6) != 0;
            flip   = PAR_EN && (($urandom % 5) == 0);
            full   = ($urandom % 4) == 0;
            run_frame($sformatf("rnd%0d_%02h", i, d), d, stop_v, flip, full);
            wait_clk($urandom_range(0, 10));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
